// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: control byte layout, mode and
// direction types, PWM width.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BAR    = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int MODE_LSB  = 6;
  localparam int MODE_W    = 2;
  localparam int SPEED_LSB = 3;
  localparam int SPEED_W   = 3;
  localparam int DUTY_LSB  = 0;
  localparam int DUTY_W    = 3;

  localparam int PWM_BITS  = 3;
  localparam int MAX_SPEED = 7;

  function automatic mode_e ctrl_mode(input logic [7:0] ctrl);
    return mode_e'(ctrl[MODE_LSB +: MODE_W]);
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate divider: counts BASE_TICKS<<speed cycles per step and flags the
// terminal count combinationally so the caller can act on that same edge.
module led_step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int BASE_TICKS = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] speed,
  input  logic       clear,
  output logic       tick
);

  localparam int CNT_W = $clog2(BASE_TICKS << MAX_SPEED);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   period;
  logic [CNT_W-1:0] last;

  // One extra bit so a power-of-two BASE_TICKS at max speed does not overflow.
  always_comb begin
    period = (CNT_W+1)'(BASE_TICKS) << speed;
    last   = CNT_W'(period - (CNT_W+1)'(1));
    tick   = !clear && (cnt_q == last);
    cnt_d  = (clear || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Turns the PIO control byte into autonomous LED animations (bounce, bar,
// blink) with programmable step rate and PWM brightness.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int BASE_TICKS = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ctrl_in,
  output logic [7:0] led,
  output logic       step_tick
);

  logic [7:0]          ctrl_q, ctrl_d;
  logic [2:0]          pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic [3:0]          level_q, level_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          led_q, led_d;
  logic                step_tick_q, step_tick_d;

  mode_e      mode;
  logic       restart;
  logic       step;
  logic       pwm_on;
  logic [7:0] pattern;

  assign mode    = ctrl_mode(ctrl_q);
  assign restart = ctrl_in[7:SPEED_LSB] != ctrl_q[7:SPEED_LSB];

  // Holding the divider clear in OFF keeps step_tick quiet while idle.
  led_step_prescaler #(.BASE_TICKS(BASE_TICKS)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .speed   (ctrl_q[SPEED_LSB +: SPEED_W]),
    .clear   (restart || (mode == MODE_OFF)),
    .tick    (step)
  );

  always_comb begin
    ctrl_d      = ctrl_in;
    pos_d       = pos_q;
    dir_d       = dir_q;
    level_d     = level_q;
    phase_d     = phase_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    step_tick_d = step;

    if (restart) begin
      pos_d   = 3'd0;
      dir_d   = DIR_UP;
      level_d = 4'd0;
      phase_d = 1'b1;
    end else if (step) begin
      unique case (mode)
        MODE_BOUNCE: begin
          // Flip direction on the step that lands on an end so it is shown once.
          if (dir_q == DIR_UP) begin
            pos_d = pos_q + 3'd1;
            if (pos_q == 3'd6) dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_q - 3'd1;
            if (pos_q == 3'd1) dir_d = DIR_UP;
          end
        end
        MODE_BAR:   level_d = (level_q == 4'd8) ? 4'd0 : level_q + 4'd1;
        MODE_BLINK: phase_d = !phase_q;
        default: ;
      endcase
    end

    unique case (mode)
      MODE_BOUNCE: pattern = 8'b1 << pos_q;
      MODE_BAR:    pattern = 8'((9'b1 << level_q) - 9'd1);
      MODE_BLINK:  pattern = {8{phase_q}};
      default:     pattern = 8'h00;
    endcase

    pwm_on = pwm_cnt_q <= ctrl_q[DUTY_LSB +: DUTY_W];
    led_d  = pattern & {8{pwm_on}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= 8'h00;
      pos_q       <= 3'd0;
      dir_q       <= DIR_UP;
      level_q     <= 4'd0;
      phase_q     <= 1'b1;
      pwm_cnt_q   <= '0;
      led_q       <= 8'h00;
      step_tick_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      level_q     <= level_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led       = led_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: per-cycle comparison against a step-count
// model, a vector table of known pattern points, and restart/reset corners.
module tb_led_pattern_engine;

  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ctrl_in;
  logic [7:0] led;
  logic       step_tick;

  led_pattern_engine #(.BASE_TICKS(BT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctrl_in   (ctrl_in),
    .led       (led),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: pattern is a pure function of the number of steps since restart.
  logic [7:0] m_ctrl, m_led;
  logic       m_tick;
  int         m_cyc, m_steps, m_pwm;

  function automatic logic [7:0] model_pattern(input logic [1:0] mode, input int k);
    int m;
    case (mode)
      2'b01: begin
        m = k % 14;
        return 8'(1 << ((m <= 7) ? m : 14 - m));
      end
      2'b10:   return 8'((1 << (k % 9)) - 1);
      2'b11:   return ((k % 2) == 0) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_led = 8'h00; m_tick = 1'b0;
    m_cyc = 0; m_steps = 0; m_pwm = 0;
  endtask

  task automatic model_edge();
    logic restart;
    int   period;
    logic [7:0] nled;
    restart = ctrl_in[7:3] != m_ctrl[7:3];
    period  = BT << m_ctrl[5:3];
    nled    = model_pattern(m_ctrl[7:6], m_steps) &
              ((m_pwm <= int'(m_ctrl[2:0])) ? 8'hFF : 8'h00);
    if (restart || m_ctrl[7:6] == 2'b00) begin
      m_cyc  = 0;
      m_tick = 1'b0;
      if (restart) m_steps = 0;
    end else begin
      m_cyc++;
      m_tick = (m_cyc % period) == 0;
      if (m_tick) m_steps++;
    end
    m_pwm  = (m_pwm + 1) % 8;
    m_led  = nled;
    m_ctrl = ctrl_in;
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic edge_chk();
    @(posedge clk);
    model_edge();
    #1;
    chk8("model_led", led, m_led);
    chk1("model_step_tick", step_tick, m_tick);
  endtask

  task automatic go_off();
    ctrl_in = 8'h00;
    repeat (3) edge_chk();
  endtask

  typedef struct {
    logic [7:0] ctrl;
    int         edges;
    logic [7:0] exp_led;
    logic       exp_tick;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic saw;
    logic [7:0] samples[512];
    int bad, on;

    // Points after a fresh restart: led after edge e shows step (e-2)/(BT<<S).
    vecs.push_back('{8'h47,  2, 8'h01, 1'b0});
    vecs.push_back('{8'h47,  5, 8'h01, 1'b1});
    vecs.push_back('{8'h47,  6, 8'h02, 1'b0});
    vecs.push_back('{8'h47, 30, 8'h80, 1'b0});
    vecs.push_back('{8'h47, 34, 8'h40, 1'b0});
    vecs.push_back('{8'h47, 58, 8'h01, 1'b0});
    vecs.push_back('{8'h47, 62, 8'h02, 1'b0});
    vecs.push_back('{8'h87,  2, 8'h00, 1'b0});
    vecs.push_back('{8'h87, 18, 8'h0F, 1'b0});
    vecs.push_back('{8'h87, 34, 8'hFF, 1'b0});
    vecs.push_back('{8'h87, 38, 8'h00, 1'b0});
    vecs.push_back('{8'hCF,  2, 8'hFF, 1'b0});
    vecs.push_back('{8'hCF,  9, 8'hFF, 1'b1});
    vecs.push_back('{8'hCF, 10, 8'h00, 1'b0});
    vecs.push_back('{8'hCF, 18, 8'hFF, 1'b0});
    vecs.push_back('{8'h07, 10, 8'h00, 1'b0});

    reset_n = 1'b0;
    ctrl_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk8("reset_led", led, 8'h00);
    chk1("reset_step_tick", step_tick, 1'b0);
    reset_n = 1'b1;

    saw = 1'b0;
    repeat (100) begin
      edge_chk();
      saw |= step_tick;
    end
    chk1("idle_no_tick", saw, 1'b0);

    foreach (vecs[i]) begin
      go_off();
      ctrl_in = vecs[i].ctrl;
      repeat (vecs[i].edges) edge_chk();
      chk8($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      chk1($sformatf("vec%0d_tick", i), step_tick, vecs[i].exp_tick);
    end

    // Speed change mid-bounce restarts from pos 0 with the new step period.
    go_off();
    ctrl_in = 8'h47;
    repeat (22) edge_chk();
    chk8("bounce_pos5", led, 8'h20);
    ctrl_in = 8'h4F;
    repeat (2) edge_chk();
    chk8("speed_restart_led", led, 8'h01);
    saw = 1'b0;
    repeat (6) begin
      edge_chk();
      saw |= step_tick;
    end
    chk1("speed_restart_early_tick", saw, 1'b0);
    edge_chk();
    chk1("speed_restart_first_tick", step_tick, 1'b1);

    // Restart coinciding with a terminal count must swallow that step.
    ctrl_in = 8'h47;
    repeat (4) edge_chk();
    ctrl_in = 8'h4F;
    edge_chk();
    chk1("coincident_tick_dropped", step_tick, 1'b0);

    // Duty-only change keeps the step cadence from the earlier restart.
    ctrl_in = 8'h47;
    repeat (14) edge_chk();
    chk8("duty_pre_led", led, 8'h08);
    ctrl_in = 8'h44;
    repeat (3) edge_chk();
    chk1("duty_no_restart_tick", step_tick, 1'b1);

    // Slow blink at half duty: any 8 consecutive cycles have exactly 4 lit.
    go_off();
    ctrl_in = 8'hFB;
    edge_chk();
    for (int i = 0; i < 512; i++) begin
      edge_chk();
      samples[i] = led;
    end
    bad = 0;
    for (int i = 0; i <= 504; i++) begin
      on = 0;
      for (int j = 0; j < 8; j++) begin
        if (samples[i+j] == 8'hFF) on++;
        else if (samples[i+j] != 8'h00) bad++;
      end
      if (on != 4) bad++;
    end
    chk8("blink_pwm_bad_windows", 8'(bad), 8'h00);

    // Asynchronous reset in the middle of a bar animation.
    go_off();
    ctrl_in = 8'h87;
    repeat (20) edge_chk();
    chk8("bar_pre_reset", led, 8'h0F);
    reset_n = 1'b0;
    #1;
    chk8("async_reset_led", led, 8'h00);
    chk1("async_reset_tick", step_tick, 1'b0);
    model_reset();
    #1;
    reset_n = 1'b1;
    repeat (40) edge_chk();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) ctrl_in[2:0] = 3'($urandom_range(0, 7));
        else begin
          ctrl_in      = 8'($urandom);
          ctrl_in[5:3] = 3'($urandom_range(0, 2));
        end
      end
      edge_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
